multicycle_seq_ctrl: RTL and testbench
======================================

Name: multicycle_seq_ctrl

Overview:
- Multi-cycle control sequencer for the R/I/S-type datapath: fetch, register-file/ALU, data memory and write-back.
- Replaces single-cycle control with an FSM that steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB.
- Generates per-stage register enables and handshakes with instruction and data memories that may stall.
- Counts retired instructions and traps on illegal encodings or memory timeouts.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles waited for imem_ready or dmem_ready before trapping.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- halt  input  1  when high in FETCH, no new fetch is issued.
- opcode  input  7  instrCode[6:0] from the instruction register.
- funct3  input  3  instrCode[14:12].
- imem_ready  input  1  instruction word valid this cycle.
- dmem_ready  input  1  data memory access complete this cycle.
- imem_req  output  1  instruction fetch request.
- ir_en  output  1  load instruction register (1-cycle pulse).
- opnd_en  output  1  latch A/B/immOut operand registers.
- alu_en  output  1  latch ALU result register.
- dmem_req  output  1  data memory request.
- dmem_rw  output  1  1 = write (store), 0 = read.
- whb  output  2  00 byte, 01 half, 10 word.
- mem_to_reg  output  1  write-back source select, 1 = memory data.
- alu_src  output  1  1 = immediate operand.
- reg_write  output  1  register-file write enable (1-cycle pulse).
- pc_en  output  1  PC advance (1-cycle pulse).
- trap  output  1  sticky error flag.
- retired  output  CNT_W  instructions completed.
- state  output  3  current FSM state code.

Behaviour:
- Reset (asynchronous, any cycle including mid-instruction):
  - state = FETCH; all outputs 0; retired = 0; trap = 0; timeout counter = 0.
  - Any in-flight instruction is abandoned.
- State codes: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, TRAP=7.
- Instruction classes:
  - R = 0110011.
  - I-ALU = 0010011.
  - LOAD = 0000011.
  - STORE = 0100011.
  - Any other opcode is illegal.
  - LOAD/STORE with funct3[1:0]=11 is illegal.
- FETCH:
  - imem_req = ~halt.
  - imem_ready high with imem_req high: ir_en pulses; go to DECODE.
  - halt=1 holds in FETCH with imem_req=0 and the timeout counter cleared.
- DECODE:
  - Legal instruction: opnd_en = 1 for one cycle; go to EXECUTE.
  - Illegal instruction: go to TRAP with no enables asserted.
- EXECUTE:
  - alu_en = 1.
  - alu_src = 0 for R, 1 otherwise; alu_src is held through MEM/WB.
  - R and I-ALU go to WB; LOAD and STORE go to MEM.
- MEM:
  - dmem_req = 1, dmem_rw = (STORE), whb = funct3[1:0]; all held stable until dmem_ready.
  - On dmem_ready, STORE: pc_en pulses, retired += 1, go to FETCH.
  - On dmem_ready, LOAD: go to WB.
- WB:
  - reg_write = 1, pc_en = 1, mem_to_reg = (LOAD); retired += 1; go to FETCH.
  - whb stays valid in WB for load sign-extension.
- Timeout:
  - The counter increments each cycle imem_req or dmem_req is high without ready, and clears on state change.
  - Reaching MEM_TIMEOUT goes to TRAP.
- TRAP:
  - trap = 1; all request and enable outputs 0.
  - Left only by reset.
- Latency, counted from the FETCH cycle with ready same-cycle:
  - R/I: 4 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each extra stall cycle adds 1.
- Counter: retired wraps from 2^CNT_W−1 to 0 without any flag.
- Exclusivity: reg_write and dmem_req are never high in the same cycle; pc_en fires exactly once per retired instruction.
- Late/changing inputs:
  - A ready arriving in the same cycle as timeout expiry counts as success; ready has priority.
  - halt asserted outside FETCH has no effect until the next FETCH.
  - opcode/funct3 are sampled every cycle but are required stable after ir_en; the controller does not latch them.

Test Plan:
- ADD (opcode 0110011), imem_ready tied 1, dmem_ready tied 1 -> states 0,1,2,4; alu_src=0; reg_write and pc_en pulse in cycle 4; retired=1.
- LW (0000011, funct3=010), dmem_ready delayed 3 cycles -> dmem_req/dmem_rw=0/whb=10 stable for 4 MEM cycles; WB with mem_to_reg=1; total 8 cycles; retired increments once.
- SB (0100011, funct3=000) -> MEM with dmem_rw=1, whb=00; pc_en on the dmem_ready cycle; reg_write never asserted.
- Opcode 1111111 and LOAD with funct3=011 -> TRAP after DECODE; trap=1, all enables 0 for 20 cycles; rst pulse returns to FETCH with trap=0.
- dmem_ready held 0, MEM_TIMEOUT=16 -> TRAP exactly 16 cycles after MEM entry; a second run with ready on the 16th cycle completes normally.
- rst asserted asynchronously mid-MEM -> outputs 0 immediately, before the next clock edge; halt=1 at release holds FETCH with imem_req=0; preload retired=2^32−1 and retire one instruction -> 0.

Source files
------------

// File: rtl/multicycle_seq_ctrl.sv
// Multi-cycle control sequencer: steps R/I/LOAD/STORE instructions
// through FETCH/DECODE/EXECUTE/MEM/WB with stall timeouts and a trap state.
module multicycle_seq_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             halt,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   output logic             imem_req,
   output logic             ir_en,
   output logic             opnd_en,
   output logic             alu_en,
   output logic             dmem_req,
   output logic             dmem_rw,
   output logic [1:0]       whb,
   output logic             mem_to_reg,
   output logic             alu_src,
   output logic             reg_write,
   output logic             pc_en,
   output logic             trap,
   output logic [CNT_W-1:0] retired,
   output logic [2:0]       state
);

   localparam logic [2:0] S_FETCH   = 3'd0;
   localparam logic [2:0] S_DECODE  = 3'd1;
   localparam logic [2:0] S_EXECUTE = 3'd2;
   localparam logic [2:0] S_MEM     = 3'd3;
   localparam logic [2:0] S_WB      = 3'd4;
   localparam logic [2:0] S_TRAP    = 3'd7;

   localparam int TW = $clog2(MEM_TIMEOUT + 1);

   logic [2:0]    next_state;
   logic [TW-1:0] tcnt;
   logic          is_r;
   logic          is_i;
   logic          is_ld;
   logic          is_st;
   logic          legal;
   logic          req_wait;
   logic          expired;

   // Instruction class decode, plus "a request is outstanding without ready"
   always_comb begin
      is_r     = (opcode == 7'b0110011);
      is_i     = (opcode == 7'b0010011);
      is_ld    = (opcode == 7'b0000011);
      is_st    = (opcode == 7'b0100011);
      legal    = is_r | is_i
               | ((is_ld | is_st) & (funct3[1:0] != 2'b11));
      req_wait = ((state == S_FETCH) & ~halt & ~imem_ready)
               | ((state == S_MEM) & ~dmem_ready);
      expired  = req_wait & (tcnt == TW'(MEM_TIMEOUT - 1));
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_FETCH;
      else     state <= next_state;
   end

   // Next-state logic; a ready in the expiry cycle wins over the timeout
   always_comb begin
      next_state = state;
      unique case (state)
         S_FETCH: begin
            if (~halt & imem_ready) next_state = S_DECODE;
            else if (expired)       next_state = S_TRAP;
         end
         S_DECODE:  next_state = legal ? S_EXECUTE : S_TRAP;
         S_EXECUTE: next_state = (is_ld | is_st) ? S_MEM : S_WB;
         S_MEM: begin
            if (dmem_ready)   next_state = is_st ? S_FETCH : S_WB;
            else if (expired) next_state = S_TRAP;
         end
         S_WB:      next_state = S_FETCH;
         S_TRAP:    next_state = S_TRAP;
         default:   next_state = S_TRAP;
      endcase
   end

   // Output decode; FETCH requests are masked while reset is held
   always_comb begin
      imem_req   = 1'b0;
      ir_en      = 1'b0;
      opnd_en    = 1'b0;
      alu_en     = 1'b0;
      dmem_req   = 1'b0;
      dmem_rw    = 1'b0;
      whb        = 2'b00;
      mem_to_reg = 1'b0;
      alu_src    = 1'b0;
      reg_write  = 1'b0;
      pc_en      = 1'b0;
      trap       = 1'b0;
      unique case (state)
         S_FETCH: begin
            imem_req = ~halt & ~rst;
            ir_en    = ~halt & ~rst & imem_ready;
         end
         S_DECODE:  opnd_en = legal;
         S_EXECUTE: begin
            alu_en  = 1'b1;
            alu_src = ~is_r;
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_rw  = is_st;
            whb      = funct3[1:0];
            alu_src  = ~is_r;
            pc_en    = is_st & dmem_ready;
         end
         S_WB: begin
            reg_write  = 1'b1;
            pc_en      = 1'b1;
            mem_to_reg = is_ld;
            whb        = is_ld ? funct3[1:0] : 2'b00;
            alu_src    = ~is_r;
         end
         S_TRAP:    trap = 1'b1;
         default:   trap = 1'b1;
      endcase
   end

   // Stall timeout counter: counts unanswered request cycles in one state
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                  tcnt <= '0;
      else if (next_state != state || !req_wait) tcnt <= '0;
      else                                      tcnt <= tcnt + 1'b1;
   end

   // Retired-instruction counter, one step per PC advance, free wrapping
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        retired <= '0;
      else if (pc_en) retired <= retired + 1'b1;
   end

endmodule

// File: tb/tb_multicycle_seq_ctrl.sv
// Self-checking bench for multicycle_seq_ctrl: an expected cycle trace is
// built per instruction from the class rules, then replayed on the DUT.
module tb_multicycle_seq_ctrl;

   localparam int TO = 16;

   localparam logic [12:0] B_IMQ  = 13'h1000;
   localparam logic [12:0] B_IR   = 13'h0800;
   localparam logic [12:0] B_OPN  = 13'h0400;
   localparam logic [12:0] B_ALU  = 13'h0200;
   localparam logic [12:0] B_DRQ  = 13'h0100;
   localparam logic [12:0] B_DRW  = 13'h0080;
   localparam logic [12:0] B_M2R  = 13'h0010;
   localparam logic [12:0] B_ASRC = 13'h0008;
   localparam logic [12:0] B_RW   = 13'h0004;
   localparam logic [12:0] B_PC   = 13'h0002;
   localparam logic [12:0] B_TRAP = 13'h0001;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011;

   logic clk = 1'b0;
   logic rst, halt, imem_ready, dmem_ready;
   logic [6:0] opcode;
   logic [2:0] funct3;

   logic imem_req, ir_en, opnd_en, alu_en, dmem_req, dmem_rw;
   logic [1:0] whb;
   logic mem_to_reg, alu_src, reg_write, pc_en, trap;
   logic [31:0] retired;
   logic [2:0] state;

   logic s_imem_req, s_ir_en, s_opnd_en, s_alu_en, s_dmem_req, s_dmem_rw;
   logic [1:0] s_whb;
   logic s_mem_to_reg, s_alu_src, s_reg_write, s_pc_en, s_trap;
   logic [3:0] s_retired;
   logic [2:0] s_state;

   logic [12:0] outs;
   assign outs = {imem_req, ir_en, opnd_en, alu_en, dmem_req, dmem_rw,
                  whb, mem_to_reg, alu_src, reg_write, pc_en, trap};

   multicycle_seq_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .halt(halt), .opcode(opcode), .funct3(funct3),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .imem_req(imem_req), .ir_en(ir_en), .opnd_en(opnd_en),
      .alu_en(alu_en), .dmem_req(dmem_req), .dmem_rw(dmem_rw), .whb(whb),
      .mem_to_reg(mem_to_reg), .alu_src(alu_src), .reg_write(reg_write),
      .pc_en(pc_en), .trap(trap), .retired(retired), .state(state));

   // Narrow-counter copy driven by the same stimulus, to exercise wrap
   multicycle_seq_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(4)) dut_s (
      .clk(clk), .rst(rst), .halt(halt), .opcode(opcode), .funct3(funct3),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .imem_req(s_imem_req), .ir_en(s_ir_en), .opnd_en(s_opnd_en),
      .alu_en(s_alu_en), .dmem_req(s_dmem_req), .dmem_rw(s_dmem_rw),
      .whb(s_whb), .mem_to_reg(s_mem_to_reg), .alu_src(s_alu_src),
      .reg_write(s_reg_write), .pc_en(s_pc_en), .trap(s_trap),
      .retired(s_retired), .state(s_state));

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  st;
      logic        hlt;
      logic        imr;
      logic        dmr;
      logic [12:0] outs;
      logic [31:0] ret;
      logic [6:0]  opc;
      logic [2:0]  f3;
   } cyc_t;

   cyc_t        q[$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] m_ret  = 0;

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic push(input logic [2:0] st, input logic hlt, input logic imr,
                       input logic dmr, input logic [12:0] o,
                       input logic [6:0] opc, input logic [2:0] f3);
      cyc_t c;
      c.st = st; c.hlt = hlt; c.imr = imr; c.dmr = dmr;
      c.outs = o; c.ret = m_ret; c.opc = opc; c.f3 = f3;
      q.push_back(c);
   endtask

   // Expected trace of one instruction: hold = halted FETCH cycles,
   // di/dd = stall cycles before imem/dmem ready, tl = trap cycles to watch
   task automatic gen(input logic [6:0] opc, input logic [2:0] f3,
                      input int hold, input int di, input int dd,
                      input int tl);
      logic isr, ism, isst, legal;
      logic [12:0] asrc, mo;
      int n;
      isr   = (opc == OP_R);
      isst  = (opc == OP_ST);
      ism   = (opc == OP_LD) || isst;
      legal = isr || (opc == OP_I) || (ism && f3[1:0] != 2'b11);
      asrc  = isr ? 13'h0 : B_ASRC;
      for (int k = 0; k < hold; k++) push(3'd0, 1, rb(), rb(), 13'h0, opc, f3);
      for (int k = 0; k < di; k++) push(3'd0, 0, 0, rb(), B_IMQ, opc, f3);
      push(3'd0, 0, 1, rb(), B_IMQ | B_IR, opc, f3);
      if (!legal) begin
         push(3'd1, rb(), rb(), rb(), 13'h0, opc, f3);
         for (int k = 0; k < tl; k++) push(3'd7, rb(), rb(), rb(), B_TRAP, opc, f3);
         return;
      end
      push(3'd1, rb(), rb(), rb(), B_OPN, opc, f3);
      push(3'd2, rb(), rb(), rb(), B_ALU | asrc, opc, f3);
      if (ism) begin
         mo = B_DRQ | (isst ? B_DRW : 13'h0) | {6'b0, f3[1:0], 5'b0} | asrc;
         n = (dd < TO) ? dd : TO;
         for (int k = 0; k < n; k++) push(3'd3, rb(), rb(), 0, mo, opc, f3);
         if (dd >= TO) begin
            for (int k = 0; k < tl; k++) push(3'd7, rb(), rb(), rb(), B_TRAP, opc, f3);
            return;
         end
         push(3'd3, rb(), rb(), 1, mo | (isst ? B_PC : 13'h0), opc, f3);
         if (isst) begin
            m_ret++;
            return;
         end
         push(3'd4, rb(), rb(), rb(),
              B_RW | B_PC | B_M2R | {6'b0, f3[1:0], 5'b0} | asrc, opc, f3);
         m_ret++;
         return;
      end
      push(3'd4, rb(), rb(), rb(), B_RW | B_PC | asrc, opc, f3);
      m_ret++;
   endtask

   // Replay up to n trace cycles (n < 0: all); inputs at posedge+1, check at negedge
   task automatic run_n(input int n);
      cyc_t c;
      int done = 0;
      while (q.size() > 0 && (n < 0 || done < n)) begin
         c = q.pop_front();
         halt = c.hlt; imem_ready = c.imr; dmem_ready = c.dmr;
         opcode = c.opc; funct3 = c.f3;
         @(negedge clk);
         checks++;
         if (state !== c.st || outs !== c.outs || retired !== c.ret ||
             s_retired !== c.ret[3:0]) begin
            errors++;
            $display("FAIL trace t=%0t state=%0d/%0d outs=%b/%b retired=%0d/%0d retired4=%0d/%0d",
                     $time, state, c.st, outs, c.outs, retired, c.ret,
                     s_retired, c.ret[3:0]);
         end
         @(posedge clk); #1;
         done++;
      end
      q.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1; halt = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
      #1;
      checks++;
      if (state !== 3'd0 || outs !== 13'h0 || retired !== 32'd0 ||
          s_retired !== 4'd0) begin
         errors++;
         $display("FAIL reset state=%0d outs=%b retired=%0d required 0/0/0", state, outs, retired);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      m_ret = 0;
   endtask

   task automatic check_ret(input string nm, input logic [31:0] exp);
      checks++;
      if (retired !== exp) begin
         errors++;
         $display("FAIL %s retired=%0d required %0d", nm, retired, exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; halt = 1'b0; opcode = OP_R; funct3 = 3'd0;
      imem_ready = 1'b0; dmem_ready = 1'b0;
      @(posedge clk); #1;
      do_reset();
   endtask

   task automatic test_add();
      gen(OP_R, 3'b000, 0, 0, 0, 0);
      run_n(-1);
      check_ret("add_retired", 32'd1);
   endtask

   task automatic test_lw();
      gen(OP_LD, 3'b010, 0, 0, 3, 0);
      run_n(-1);
      check_ret("lw_retired", 32'd2);
   endtask

   task automatic test_sb();
      gen(OP_ST, 3'b000, 0, 0, 2, 0);
      run_n(-1);
      check_ret("sb_retired", 32'd3);
   endtask

   task automatic test_illegal();
      gen(7'b1111111, 3'b000, 0, 0, 0, 20);
      run_n(-1);
      do_reset();
      gen(OP_LD, 3'b011, 0, 1, 0, 20);
      run_n(-1);
      do_reset();
   endtask

   task automatic test_timeout();
      gen(OP_LD, 3'b010, 0, 0, TO, 5);
      run_n(-1);
      do_reset();
      gen(OP_ST, 3'b001, 0, 0, TO - 1, 0);
      run_n(-1);
      check_ret("ready_at_expiry", 32'd1);
   endtask

   task automatic test_async_reset();
      gen(OP_LD, 3'b010, 0, 0, 10, 0);
      run_n(8);
      dmem_ready = 1'b0;
      #2;
      checks++;
      if (state !== 3'd3 || dmem_req !== 1'b1) begin
         errors++;
         $display("FAIL mid_mem state=%0d dmem_req=%b required 3/1", state, dmem_req);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (state !== 3'd0 || outs !== 13'h0 || retired !== 32'd0) begin
         errors++;
         $display("FAIL async_rst state=%0d outs=%b retired=%0d required 0/0/0", state, outs, retired);
      end
      halt = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      m_ret = 0;
      for (int k = 0; k < 5; k++) begin
         imem_ready = rb();
         @(negedge clk);
         checks++;
         if (state !== 3'd0 || outs !== 13'h0) begin
            errors++;
            $display("FAIL halt_hold state=%0d outs=%b required 0/0", state, outs);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_random();
      logic [6:0] opc;
      logic [2:0] f3;
      logic [6:0] ops [4];
      ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LD; ops[3] = OP_ST;
      do_reset();
      for (int i = 0; i < 30; i++) begin
         opc = ops[$urandom_range(0, 3)];
         f3  = 3'($urandom_range(0, 7));
         if ((opc == OP_LD || opc == OP_ST) && f3[1:0] == 2'b11) f3[1:0] = 2'b10;
         gen(opc, f3, $urandom_range(0, 2), $urandom_range(0, 3),
             $urandom_range(0, 4), 0);
         run_n(-1);
      end
      check_ret("random_retired", 32'd30);
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < 15; i++) begin
         gen(OP_I, 3'($urandom_range(0, 7)), 0, 0, 0, 0);
         run_n(-1);
      end
      checks++;
      if (s_retired !== 4'd15) begin
         errors++;
         $display("FAIL wrap_pre retired4=%0d required 15", s_retired);
      end
      gen(OP_R, 3'b000, 0, 0, 0, 0);
      run_n(-1);
      checks++;
      if (s_retired !== 4'd0) begin
         errors++;
         $display("FAIL wrap retired4=%0d required 0", s_retired);
      end
      check_ret("wrap_wide", 32'd16);
   endtask

   initial begin
      test_reset();
      test_add();
      test_lw();
      test_sb();
      test_illegal();
      test_timeout();
      test_async_reset();
      test_random();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
